// File: rtl/hazard_ctrl_unit.sv
// Load-use, branch-flush and memory-freeze hazard control beside the ID stage.
// Combinational outputs from registered state; a freeze from data memory overrides all other actions.
module hazard_ctrl_unit #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int RW = $clog2(LOAD_STALL_CYCLES + 1);
    localparam logic [RW-1:0] REMAIN_INIT = RW'(LOAD_STALL_CYCLES - 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     remain_q, remain_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hazard;

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        freeze       = 1'b0;
        state_d      = state_q;
        remain_d     = remain_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        // Outputs stay at their defaults while reset is asserted.
        if (rst_n) begin
            if (mem_busy) begin
                freeze      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = IDLE;
                remain_d    = '0;
                flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + 1'b1;
            end else if ((state_q == STALL) || hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_cnt_d  = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
                if (state_q == STALL) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == RW'(1)) begin
                        state_d = IDLE;
                    end
                end else if (LOAD_STALL_CYCLES > 1) begin
                    state_d  = STALL;
                    remain_d = REMAIN_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: four parameterisations share one stimulus stream and a pending-bubble model.
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;

    logic [3:0] pc_w, ifid_w, bub, fi, fe, fz;
    logic [15:0] sc0, sc1, sc3, fc0, fc1, fc3;
    logic [3:0]  sc2, fc2;
    logic [3:0][15:0] scnt, fcnt;

    assign scnt = {sc3, {12'd0, sc2}, sc1, sc0};
    assign fcnt = {fc3, {12'd0, fc2}, fc1, fc0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[0]), .if_id_write(ifid_w[0]), .id_ex_bubble(bub[0]),
        .flush_if_id(fi[0]), .flush_id_ex(fe[0]), .freeze(fz[0]),
        .stall_count(sc0), .flush_count(fc0));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[1]), .if_id_write(ifid_w[1]), .id_ex_bubble(bub[1]),
        .flush_if_id(fi[1]), .flush_id_ex(fe[1]), .freeze(fz[1]),
        .stall_count(sc1), .flush_count(fc1));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[2]), .if_id_write(ifid_w[2]), .id_ex_bubble(bub[2]),
        .flush_if_id(fi[2]), .flush_id_ex(fe[2]), .freeze(fz[2]),
        .stall_count(sc2), .flush_count(fc2));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(4), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[3]), .if_id_write(ifid_w[3]), .id_ex_bubble(bub[3]),
        .flush_if_id(fi[3]), .flush_id_ex(fe[3]), .freeze(fz[3]),
        .stall_count(sc3), .flush_count(fc3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc%0d: got %0d want %0d", name, inst, cyc, act, exp);
        end
    endtask

    // Reference: each instance owes some number of further bubbles; a hazard seen
    // with nothing owed costs L bubbles in total, the current one included.
    int lcyc[4] = '{1, 3, 1, 4};
    int cmax[4] = '{65535, 65535, 15, 65535};
    int pend[4], msc[4], mfc[4];
    int npend[4], nsc[4], nfc[4];
    bit model_valid = 1'b0;

    always @(negedge clk) begin
        bit hz;
        int e_pc, e_ifid, e_bub, e_fi, e_fe, e_fz;
        hz = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        for (int i = 0; i < 4; i++) begin
            e_pc = 1; e_ifid = 1; e_bub = 0; e_fi = 0; e_fe = 0; e_fz = 0;
            npend[i] = pend[i]; nsc[i] = msc[i]; nfc[i] = mfc[i];
            if (!rst_n) begin
                npend[i] = 0; nsc[i] = 0; nfc[i] = 0;
            end else if (mem_busy) begin
                e_fz = 1; e_pc = 0; e_ifid = 0;
            end else if (branch_taken) begin
                e_fi = 1; e_fe = 1;
                npend[i] = 0;
                nfc[i] = (mfc[i] < cmax[i]) ? mfc[i] + 1 : mfc[i];
            end else if (pend[i] > 0 || hz) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
                nsc[i] = (msc[i] < cmax[i]) ? msc[i] + 1 : msc[i];
                npend[i] = (pend[i] > 0) ? pend[i] - 1 : lcyc[i] - 1;
            end
            if (model_valid || !rst_n) begin
                chk("pc_write", i, int'(pc_w[i]), e_pc);
                chk("if_id_write", i, int'(ifid_w[i]), e_ifid);
                chk("id_ex_bubble", i, int'(bub[i]), e_bub);
                chk("flush_if_id", i, int'(fi[i]), e_fi);
                chk("flush_id_ex", i, int'(fe[i]), e_fe);
                chk("freeze", i, int'(fz[i]), e_fz);
            end
            if (model_valid) begin
                chk("stall_count", i, int'(scnt[i]), msc[i]);
                chk("flush_count", i, int'(fcnt[i]), mfc[i]);
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            pend[i] <= npend[i];
            msc[i]  <= nsc[i];
            mfc[i]  <= nfc[i];
        end
        if (!rst_n) model_valid <= 1'b1;
    end

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic mr, input logic br, input logic bz);
        @(posedge clk);
        #1;
        rst_n = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_mem_read = mr;
        branch_taken = br; mem_busy = bz;
        @(negedge clk);
    endtask

    task automatic hz_cyc();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_cyc();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_cyc();
        drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; id_rs1 = 5'd5; id_rs2 = 5'd0; ex_rd = 5'd5;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; ex_mem_read = 1'b1;
        branch_taken = 1'b0; mem_busy = 1'b0;

        rst_cyc();
        rst_cyc();
        chk("rst_pc_all", 0, int'(pc_w), 15);
        chk("rst_bub_all", 0, int'(bub), 0);
        chk("rst_sc", 1, int'(scnt[1]), 0);
        chk("rst_fc", 1, int'(fcnt[1]), 0);

        hz_cyc();
        chk("l1_bub", 0, int'(bub[0]), 1);
        chk("l1_pc", 0, int'(pc_w[0]), 0);
        cnt = int'(bub[1]);
        idle_cyc();
        chk("l1_end", 0, int'(bub[0]), 0);
        cnt += int'(bub[1]);
        for (int k = 0; k < 4; k++) begin
            idle_cyc();
            cnt += int'(bub[1]);
        end
        chk("l3_bubbles", 1, cnt, 3);
        chk("l1_sc", 0, int'(scnt[0]), 1);
        chk("l3_sc", 1, int'(scnt[1]), 3);
        chk("l4_sc", 3, int'(scnt[3]), 4);

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("x0_no_stall", 0, int'(bub), 0);
        drive(1'b1, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rs2_unused", 0, int'(bub), 0);
        idle_cyc();
        chk("l3_sc_hold", 1, int'(scnt[1]), 3);

        rst_cyc();
        hz_cyc();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("br_fi", 1, int'(fi[1]), 1);
        chk("br_fe", 1, int'(fe[1]), 1);
        chk("br_bub", 1, int'(bub[1]), 0);
        chk("br_pc", 1, int'(pc_w[1]), 1);
        idle_cyc();
        chk("br_after_bub", 1, int'(bub[1]), 0);
        chk("br_after_pc", 1, int'(pc_w[1]), 1);
        chk("br_sc", 1, int'(scnt[1]), 1);
        chk("br_fc", 1, int'(fcnt[1]), 1);

        rst_cyc();
        hz_cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            chk("frz_freeze", 1, int'(fz[1]), 1);
            chk("frz_sc", 1, int'(scnt[1]), 1);
        end
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            idle_cyc();
            cnt += int'(bub[1]);
        end
        chk("frz_resume", 1, cnt, 2);
        chk("frz_sc_total", 1, int'(scnt[1]), 3);

        rst_cyc();
        for (int k = 0; k < 20; k++) begin
            hz_cyc();
            idle_cyc();
        end
        chk("sat_sc", 2, int'(scnt[2]), 15);
        chk("nosat_sc", 0, int'(scnt[0]), 20);

        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
